// File: rtl/i2s_pkg.sv
// Shared state encoding and serial-mode constants for the I2S/TDM clocking blocks.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_TDM = 1'b1;

endpackage

// File: rtl/i2s_bclk_counter.sv
// Half-period counter: tick_c fires every factor+1 cycles while run is high.
module i2s_bclk_counter
    import i2s_pkg::*;
#(
    parameter int unsigned FACTOR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [FACTOR_W-1:0] factor,
    output logic                tick_c
);

    logic [FACTOR_W-1:0] cnt;

    assign tick_c = run && (cnt == factor);

    // Count up to factor and restart; held at zero while idle so the first half-period is exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + FACTOR_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tdm_clock_divider.sv
// Generates bclk/lrck plus bit and frame timing for I2S or TDM serial audio from mclki.
module i2s_tdm_clock_divider
    import i2s_pkg::*;
#(
    parameter int unsigned FACTOR_W = 5,
    parameter int unsigned WIDTH_W  = 6,
    parameter int unsigned CH_W     = 4
) (
    input  logic                mclki,
    input  logic                rst,
    input  logic                enable,
    input  logic [FACTOR_W-1:0] bclk_factor,
    input  logic [WIDTH_W-1:0]  word_width,
    input  logic [CH_W-1:0]     ch_count,
    input  logic                tdm_mode,
    output logic                bclk,
    output logic                lrck,
    output logic                bit_strobe,
    output logic                frame_start,
    output logic [CH_W-1:0]     slot_idx,
    output logic [WIDTH_W-1:0]  bit_idx,
    output logic                busy
);

    state_t              state;
    logic [FACTOR_W-1:0] sh_factor;
    logic [WIDTH_W-1:0]  sh_width;
    logic [CH_W-1:0]     sh_ch_count;
    logic                sh_tdm;

    logic                run_c;
    logic                tick_c;
    logic                fall_c;
    logic                frame_end_c;
    logic                finish_c;
    logic                latch_c;
    logic [WIDTH_W-1:0]  in_width_c;
    logic [WIDTH_W-1:0]  nxt_bit_c;
    logic [CH_W-1:0]     nxt_slot_c;
    logic                nxt_lrck_c;

    // Word-select level for a given position: TDM sync pulse or I2S left/right half.
    function automatic logic lrck_for(input logic tdm, input logic [CH_W-1:0] slot,
                                      input logic [WIDTH_W-1:0] bit_n, input logic [CH_W-1:0] chc);
        logic [CH_W:0] half;
        half = ({1'b0, chc} + (CH_W+1)'(1)) >> 1;
        if (tdm == MODE_TDM) begin
            return (slot == '0) && (bit_n == '0);
        end
        return {1'b0, slot} >= half;
    endfunction

    i2s_bclk_counter #(
        .FACTOR_W (FACTOR_W)
    ) u_bclk_counter (
        .clk    (mclki),
        .rst    (rst),
        .run    (run_c),
        .factor (sh_factor),
        .tick_c (tick_c)
    );

    // Bit/slot advance, frame boundary and stop detection for the upcoming bclk fall.
    always_comb begin
        run_c       = (state != ST_IDLE);
        fall_c      = tick_c && bclk;
        in_width_c  = (word_width < WIDTH_W'(2)) ? WIDTH_W'(2) : word_width;
        frame_end_c = (bit_idx == sh_width - WIDTH_W'(1)) && (slot_idx == sh_ch_count);
        nxt_bit_c   = bit_idx + WIDTH_W'(1);
        nxt_slot_c  = slot_idx;
        if (bit_idx == sh_width - WIDTH_W'(1)) begin
            nxt_bit_c  = '0;
            nxt_slot_c = (slot_idx == sh_ch_count) ? '0 : slot_idx + CH_W'(1);
        end
        finish_c    = (state == ST_STOP) && !enable && fall_c && frame_end_c;
        latch_c     = ((state == ST_IDLE) && enable) || (fall_c && frame_end_c && !finish_c);
        nxt_lrck_c  = frame_end_c ? lrck_for(tdm_mode, '0, '0, ch_count)
                                  : lrck_for(sh_tdm, nxt_slot_c, nxt_bit_c, sh_ch_count);
    end

    // Shadow configuration is captured only at start and at frame boundaries.
    always_ff @(posedge mclki or posedge rst) begin
        if (rst) begin
            sh_factor   <= '0;
            sh_width    <= '0;
            sh_ch_count <= '0;
            sh_tdm      <= 1'b0;
        end else if (latch_c) begin
            sh_factor   <= bclk_factor;
            sh_width    <= in_width_c;
            sh_ch_count <= ch_count;
            sh_tdm      <= tdm_mode;
        end
    end

    // Control FSM with registered clock, strobe and index outputs.
    always_ff @(posedge mclki or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bclk        <= 1'b0;
            lrck        <= 1'b0;
            bit_strobe  <= 1'b0;
            frame_start <= 1'b0;
            slot_idx    <= '0;
            bit_idx     <= '0;
            busy        <= 1'b0;
        end else begin
            bit_strobe  <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state       <= ST_RUN;
                        busy        <= 1'b1;
                        bit_strobe  <= 1'b1;
                        frame_start <= 1'b1;
                        bclk        <= 1'b0;
                        slot_idx    <= '0;
                        bit_idx     <= '0;
                        lrck        <= lrck_for(tdm_mode, '0, '0, ch_count);
                    end
                end
                ST_RUN, ST_STOP: begin
                    if ((state == ST_RUN) && !enable) begin
                        state <= ST_STOP;
                    end else if ((state == ST_STOP) && enable) begin
                        state <= ST_RUN;
                    end
                    if (tick_c && !bclk) begin
                        bclk <= 1'b1;
                    end else if (finish_c) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        bclk     <= 1'b0;
                        lrck     <= 1'b0;
                        slot_idx <= '0;
                        bit_idx  <= '0;
                    end else if (fall_c) begin
                        bclk        <= 1'b0;
                        bit_strobe  <= 1'b1;
                        frame_start <= frame_end_c;
                        bit_idx     <= nxt_bit_c;
                        slot_idx    <= nxt_slot_c;
                        lrck        <= nxt_lrck_c;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tdm_clock_divider.sv
// Directed, table-driven bench for i2s_tdm_clock_divider.
module tb_i2s_tdm_clock_divider;

    localparam int unsigned FACTOR_W = 5;
    localparam int unsigned WIDTH_W  = 6;
    localparam int unsigned CH_W     = 4;

    logic                mclki = 1'b0;
    logic                rst;
    logic                enable;
    logic [FACTOR_W-1:0] bclk_factor;
    logic [WIDTH_W-1:0]  word_width;
    logic [CH_W-1:0]     ch_count;
    logic                tdm_mode;
    logic                bclk;
    logic                lrck;
    logic                bit_strobe;
    logic                frame_start;
    logic [CH_W-1:0]     slot_idx;
    logic [WIDTH_W-1:0]  bit_idx;
    logic                busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int factor;
        int width;
        int chc;
        bit tdm;
        int lrck0;
        int frame_len;
        int lrck_hi;
        int rises;
        int period;
    } vec_t;

    vec_t vecs[5];

    i2s_tdm_clock_divider #(
        .FACTOR_W (FACTOR_W),
        .WIDTH_W  (WIDTH_W),
        .CH_W     (CH_W)
    ) dut (
        .mclki       (mclki),
        .rst         (rst),
        .enable      (enable),
        .bclk_factor (bclk_factor),
        .word_width  (word_width),
        .ch_count    (ch_count),
        .tdm_mode    (tdm_mode),
        .bclk        (bclk),
        .lrck        (lrck),
        .bit_strobe  (bit_strobe),
        .frame_start (frame_start),
        .slot_idx    (slot_idx),
        .bit_idx     (bit_idx),
        .busy        (busy)
    );

    always #5 mclki = ~mclki;

    task automatic tick();
        @(negedge mclki);
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input int f, input int w, input int c, input bit t);
        bclk_factor = FACTOR_W'(f);
        word_width  = WIDTH_W'(w);
        ch_count    = CH_W'(c);
        tdm_mode    = t;
    endtask

    task automatic wait_fs(input int budget, output int at);
        bit ok;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (frame_start) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        if (!ok) check("frame_start_timeout", 0, 1);
    endtask

    task automatic wait_pos(input int slot, input int bit_n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (int'(slot_idx) == slot && int'(bit_idx) == bit_n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("position_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget, output bit saw_fs);
        bit ok;
        ok     = 1'b0;
        saw_fs = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (frame_start) saw_fs = 1'b1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    // Called on a frame_start sample; counts until the next frame_start sample.
    task automatic measure_frame(output int len, output int lrck_hi, output int rises,
                                 output int strobes, output int period);
        bit ok;
        bit prev;
        int r1;
        ok      = 1'b0;
        len     = 1;
        lrck_hi = int'(lrck);
        strobes = int'(bit_strobe);
        rises   = 0;
        period  = 0;
        r1      = -1;
        prev    = bclk;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
            len++;
            lrck_hi += int'(lrck);
            strobes += int'(bit_strobe);
            if (bclk && !prev) begin
                rises++;
                if (r1 < 0) r1 = len;
                else if (period == 0) period = len - r1;
            end
            prev = bclk;
        end
        if (!ok) check("frame_timeout", 0, 1);
    endtask

    initial begin
        int  len, lhi, rises, strobes, period;
        int  c0, c1, c2;
        bit  saw_fs;
        bit  busy_dropped;

        //           factor width chc tdm lrck0 frame lrck_hi rises period
        vecs[0] = '{0,  16, 1, 1'b0, 0,   64,   32, 32,  2};
        vecs[1] = '{3,  32, 7, 1'b1, 1, 2048,    8, 256, 8};
        vecs[2] = '{1,   0, 0, 1'b0, 1,    8,    8,  2,  4};
        vecs[3] = '{31,  2, 1, 1'b1, 1,  256,   64,  4, 64};
        vecs[4] = '{2,   3, 2, 1'b0, 0,   54,   36,  9,  6};

        rst    = 1'b1;
        enable = 1'b0;
        set_cfg(0, 16, 1, 1'b0);
        repeat (3) tick();
        check("reset_outputs", {busy, bclk, lrck, bit_strobe, frame_start, slot_idx, bit_idx}, 0);
        rst = 1'b0;
        tick();
        check("idle_without_enable", busy, 0);

        for (int i = 0; i < 5; i++) begin
            set_cfg(vecs[i].factor, vecs[i].width, vecs[i].chc, vecs[i].tdm);
            enable = 1'b1;
            tick();
            check($sformatf("v%0d_first_cycle", i), {busy, bit_strobe, frame_start, bclk}, 4'b1110);
            check($sformatf("v%0d_first_idx", i), {slot_idx, bit_idx}, 0);
            check($sformatf("v%0d_first_lrck", i), lrck, vecs[i].lrck0);
            measure_frame(len, lhi, rises, strobes, period);
            check($sformatf("v%0d_frame_len", i), len, vecs[i].frame_len);
            check($sformatf("v%0d_lrck_high", i), lhi, vecs[i].lrck_hi);
            check($sformatf("v%0d_bclk_rises", i), rises, vecs[i].rises);
            check($sformatf("v%0d_bit_strobes", i), strobes, vecs[i].rises);
            check($sformatf("v%0d_bclk_period", i), period, vecs[i].period);
            enable = 1'b0;
            wait_idle(5000, saw_fs);
            check($sformatf("v%0d_stop_outputs", i),
                  {bclk, lrck, bit_strobe, frame_start, slot_idx, bit_idx}, 0);
        end

        // Width change mid-frame takes effect only from the next frame.
        set_cfg(0, 16, 1, 1'b0);
        enable = 1'b1;
        tick();
        c0 = cyc;
        wait_pos(1, 5, 200);
        word_width = WIDTH_W'(24);
        wait_fs(200, c1);
        wait_fs(200, c2);
        check("width_change_cur_frame", c1 - c0, 64);
        check("width_change_next_frame", c2 - c1, 96);
        enable = 1'b0;
        wait_idle(500, saw_fs);

        // Stop mid-frame: frame completes, busy drops with the final bclk fall.
        set_cfg(0, 16, 1, 1'b0);
        enable = 1'b1;
        tick();
        c0 = cyc;
        wait_pos(0, 3, 200);
        enable = 1'b0;
        wait_idle(200, saw_fs);
        check("stop_busy_fall_cycle", cyc - c0, 64);
        check("stop_no_frame_start", saw_fs, 0);
        check("stop_final_outputs", {bclk, lrck, bit_strobe, slot_idx, bit_idx}, 0);

        // Re-enable while stopping: next frame follows with no gap.
        enable = 1'b1;
        tick();
        c0 = cyc;
        wait_pos(0, 3, 200);
        enable = 1'b0;
        busy_dropped = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!busy) busy_dropped = 1'b1;
        end
        enable = 1'b1;
        wait_fs(200, c1);
        check("reenable_no_gap", c1 - c0, 64);
        check("reenable_busy_held", busy_dropped, 0);

        // Reset between edges clears outputs asynchronously; restart with clamped width.
        wait_pos(1, 2, 200);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs",
                 {busy, bclk, lrck, bit_strobe, frame_start, slot_idx, bit_idx}, 0);
        word_width = '0;
        #1 rst = 1'b0;
        tick();
        check("post_reset_start", {busy, bit_strobe, frame_start, bclk}, 4'b1110);
        measure_frame(len, lhi, rises, strobes, period);
        check("clamp_frame_len", len, 8);
        check("clamp_lrck_high", lhi, 4);
        check("clamp_bclk_rises", rises, 4);
        enable = 1'b0;
        wait_idle(200, saw_fs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
